// File: rtl/filt_fir_tdm_sched.sv
// Round-robin TDM scheduler: shares one channel-interleaved FIR among gp_nr_ch requesters and routes results back by tag.
// Optional statistics outputs (o_nr_of_samples, o_starve) are built when FILT_FIR_TDM_SCHED_STATS_EN is defined.
module filt_fir_tdm_sched #(
  parameter int gp_nr_ch     = 4,
  parameter int gp_inp_width = 16,
  parameter int gp_oup_width = 32,
  parameter int gp_fir_lat   = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_ena,
  input  logic [gp_nr_ch-1:0]                i_req,
  input  logic [gp_nr_ch*gp_inp_width-1:0]   i_data,
  input  logic                               i_flush,
  output logic [gp_nr_ch-1:0]                o_ack,
  output logic                               o_fir_ena,
  output logic [gp_inp_width-1:0]            o_fir_data,
  output logic [$clog2(gp_nr_ch)-1:0]        o_fir_ch,
  input  logic [gp_oup_width-1:0]            i_fir_data,
  output logic                               o_valid,
  output logic [$clog2(gp_nr_ch)-1:0]        o_ch,
  output logic [gp_oup_width-1:0]            o_data,
  output logic                               o_busy
`ifdef FILT_FIR_TDM_SCHED_STATS_EN
  ,
  output logic [31:0]                        o_nr_of_samples,
  output logic [gp_nr_ch-1:0]                o_starve
`endif
);

  localparam int CW   = $clog2(gp_nr_ch);
  localparam int CNTW = $clog2(gp_fir_lat + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]              state;
  logic [CNTW-1:0]         flush_cnt;
  logic [CW-1:0]           ptr;
  logic [gp_inp_width-1:0] samp [gp_nr_ch];
  logic                    win_found;
  logic [CW-1:0]           win_ch;
  logic [CW-1:0]           cand;
  logic [gp_nr_ch-1:0]     win_onehot;
  logic                    grant;
  logic [gp_fir_lat-1:0]   tag_vld;
  logic [CW-1:0]           tag_ch [gp_fir_lat];

  genvar gi;
  generate
    for (gi = 0; gi < gp_nr_ch; gi++) begin : g_slice
      assign samp[gi] = i_data[gi*gp_inp_width +: gp_inp_width];
    end
  endgenerate

  // Search starts just above the last winner so a held request cannot win twice while others wait.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    cand      = '0;
    for (int k = 1; k <= gp_nr_ch; k++) begin
      cand = CW'((int'(ptr) + k) % gp_nr_ch);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_ch    = cand;
      end
    end
  end

  assign win_onehot = {{(gp_nr_ch-1){1'b0}}, 1'b1} << win_ch;
  assign grant      = i_ena && !i_flush && (state != ST_FLUSH) && win_found;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      ptr        <= CW'(gp_nr_ch - 1);
      o_ack      <= '0;
      o_fir_ena  <= 1'b0;
      o_fir_data <= '0;
      o_fir_ch   <= '0;
    end else begin
      o_ack     <= '0;
      o_fir_ena <= grant;
      if (grant) begin
        o_ack      <= win_onehot;
        o_fir_data <= samp[win_ch];
        o_fir_ch   <= win_ch;
        ptr        <= win_ch;
      end
      if (i_flush) begin
        state     <= ST_FLUSH;
        flush_cnt <= CNTW'(gp_fir_lat + 1);
      end else begin
        case (state)
          ST_IDLE:  if (i_ena && (|i_req)) state <= ST_RUN;
          ST_RUN:   if (!(|i_req)) state <= ST_IDLE;
          ST_FLUSH: begin
            flush_cnt <= flush_cnt - CNTW'(1);
            if (flush_cnt == CNTW'(1)) state <= ST_IDLE;
          end
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  // Tag pipeline mirrors the filter latency; the last stage marks the cycle i_fir_data is valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_vld <= '0;
      for (int k = 0; k < gp_fir_lat; k++) tag_ch[k] <= '0;
    end else begin
      tag_vld[0] <= o_fir_ena;
      tag_ch[0]  <= o_fir_ch;
      for (int k = 1; k < gp_fir_lat; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_ch[k]  <= tag_ch[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= tag_vld[gp_fir_lat-1];
      if (tag_vld[gp_fir_lat-1]) begin
        o_ch   <= tag_ch[gp_fir_lat-1];
        o_data <= i_fir_data;
      end
    end
  end

  assign o_busy = (state == ST_FLUSH) | (|tag_vld);

`ifdef FILT_FIR_TDM_SCHED_STATS_EN
  localparam int SW = $clog2(2*gp_nr_ch + 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_nr_of_samples <= '0;
    else if (tag_vld[gp_fir_lat-1]) o_nr_of_samples <= o_nr_of_samples + 32'd1;
  end

  // A channel is flagged once its request has waited more than 2*gp_nr_ch cycles unacknowledged.
  generate
    for (gi = 0; gi < gp_nr_ch; gi++) begin : g_starve
      logic [SW-1:0] wait_cnt;
      logic          flag;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          wait_cnt <= '0;
          flag     <= 1'b0;
        end else if (i_req[gi] && !o_ack[gi]) begin
          if (wait_cnt == SW'(2*gp_nr_ch)) flag <= 1'b1;
          else wait_cnt <= wait_cnt + SW'(1);
        end else begin
          wait_cnt <= '0;
        end
      end
      assign o_starve[gi] = flag;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_filt_fir_tdm_sched.sv
// Randomized scoreboard bench for filt_fir_tdm_sched: round-robin model predicts acks and tagged results.
module tb_filt_fir_tdm_sched;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int OW = 32;
  localparam int L  = 3;
  localparam int CW = $clog2(N);

  typedef struct { int cyc; int ch; logic [W-1:0] smp; } ack_t;
  typedef struct { int cyc; int ch; logic [OW-1:0] d; } res_t;

  logic          clk = 1'b0;
  logic          rst, ena, flush;
  logic [N-1:0]  req;
  logic [N*W-1:0] data;
  logic [N-1:0]  ack;
  logic          fir_ena;
  logic [W-1:0]  fir_data;
  logic [CW-1:0] fir_ch;
  logic [OW-1:0] fir_in;
  logic          valid;
  logic [CW-1:0] ch;
  logic [OW-1:0] dout;
  logic          busy;
`ifdef FILT_FIR_TDM_SCHED_STATS_EN
  logic [31:0]   nr_samples;
  logic [N-1:0]  starve;
`endif

  filt_fir_tdm_sched #(.gp_nr_ch(N), .gp_inp_width(W), .gp_oup_width(OW), .gp_fir_lat(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_req(req), .i_data(data), .i_flush(flush),
    .o_ack(ack), .o_fir_ena(fir_ena), .o_fir_data(fir_data), .o_fir_ch(fir_ch),
    .i_fir_data(fir_in), .o_valid(valid), .o_ch(ch), .o_data(dout), .o_busy(busy)
`ifdef FILT_FIR_TDM_SCHED_STATS_EN
    , .o_nr_of_samples(nr_samples), .o_starve(starve)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [N-1:0] pend;
  logic [W-1:0] samp [N];
  bit           hold_mode;
  int           ptr_m;
  int           n_res_exp;
  bit           mon_en = 1'b0;
  ack_t         ack_q [$];
  res_t         res_q [$];
  int           flush_log [$];

  function automatic logic [OW-1:0] fmodel(input logic [W-1:0] x, input int c);
    return (32'(c) << 28) ^ ({16'h0, x} * 32'd5) ^ 32'h00A5_0000;
  endfunction

  // Stand-in filter: fixed latency L from the sample strobe, noise when no result is due.
  logic          dl_v [L];
  logic [W-1:0]  dl_d [L];
  logic [CW-1:0] dl_c [L];
  logic [OW-1:0] noise;
  always @(posedge clk) begin
    dl_v[0] <= fir_ena; dl_d[0] <= fir_data; dl_c[0] <= fir_ch;
    for (int k = 1; k < L; k++) begin
      dl_v[k] <= dl_v[k-1]; dl_d[k] <= dl_d[k-1]; dl_c[k] <= dl_c[k-1];
    end
    noise <= $urandom;
  end
  assign fir_in = dl_v[L-1] ? fmodel(dl_d[L-1], int'(dl_c[L-1])) : noise;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit blocked(input int c);
    foreach (flush_log[i]) if (flush_log[i] <= c && c <= flush_log[i] + L + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick();
    for (int k = 1; k <= N; k++) if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // One clock cycle of stimulus; the model decides the grant from the inputs it just drove.
  task automatic cycle(input bit en, input bit fl, input int pct);
    int   w;
    ack_t a;
    res_t r;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++)
      if (!pend[k] && $urandom_range(99) < pct) begin pend[k] = 1'b1; samp[k] = W'($urandom); end
    ena = en; flush = fl; req = pend;
    for (int k = 0; k < N; k++) data[k*W +: W] = samp[k];
    if (fl) flush_log.push_back(cyc);
    if (en && !blocked(cyc) && pend != '0) begin
      w = pick();
      ptr_m = w;
      a.cyc = cyc + 1; a.ch = w; a.smp = samp[w]; ack_q.push_back(a);
      r.cyc = cyc + L + 2; r.ch = w; r.d = fmodel(samp[w], w); res_q.push_back(r);
      if (hold_mode) samp[w] = W'($urandom);
      else pend[w] = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (pend != '0 && guard < 200) begin cycle(1'b1, 1'b0, 0); guard++; end
    repeat (L + 4) cycle(1'b1, 1'b0, 0);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; ena = 1'b0; flush = 1'b0; req = '0; pend = '0; hold_mode = 1'b0;
    ack_q.delete(); res_q.delete(); flush_log.delete(); ptr_m = N - 1; n_res_exp = 0;
    #1;
    chk("rst_ack", ack, 0);       chk("rst_fir_ena", fir_ena, 0);
    chk("rst_fir_data", fir_data, 0); chk("rst_fir_ch", fir_ch, 0);
    chk("rst_valid", valid, 0);   chk("rst_ch", ch, 0);
    chk("rst_data", dout, 0);     chk("rst_busy", busy, 0);
    mon_en = 1'b1;
    repeat (n) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  // Monitor: pops expectations when their cycle comes up, otherwise expects quiet outputs.
  ack_t         m_a;
  res_t         m_r;
  logic [N-1:0] m_ack;
  bit           m_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      m_busy = 1'b0;
      foreach (flush_log[i]) if (flush_log[i] < cyc && cyc <= flush_log[i] + L + 1) m_busy = 1'b1;
      foreach (res_q[i]) if (res_q[i].cyc - L <= cyc && cyc < res_q[i].cyc) m_busy = 1'b1;
      chk("busy", busy, m_busy);
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        m_a = ack_q.pop_front();
        m_ack = '0; m_ack[m_a.ch] = 1'b1;
        chk("ack", ack, m_ack);
        chk("fir_ena", fir_ena, 1);
        chk("fir_ch", fir_ch, m_a.ch);
        chk("fir_data", fir_data, m_a.smp);
      end else begin
        chk("ack_idle", ack, 0);
        chk("fir_ena_idle", fir_ena, 0);
      end
      if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
        m_r = res_q.pop_front();
        n_res_exp++;
        chk("valid", valid, 1);
        chk("res_ch", ch, m_r.ch);
        chk("res_data", dout, m_r.d);
        $display("result cycle %0d ch=%0d data=%08h expect ch=%0d data=%08h",
                 cyc, ch, dout, m_r.ch, m_r.d);
      end else begin
        chk("valid_idle", valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ena = 1'b0; flush = 1'b0; req = '0; data = '0;
    pend = '0; hold_mode = 1'b0; ptr_m = N - 1; n_res_exp = 0;
    for (int k = 0; k < N; k++) samp[k] = '0;
    apply_reset(2);

    // Single request on ch2
    pend[2] = 1'b1; samp[2] = 16'h1234;
    cycle(1'b1, 1'b0, 0);
    repeat (L + 4) cycle(1'b1, 1'b0, 0);

    // All channels held: strict rotation, one grant per cycle
    hold_mode = 1'b1; pend = '1;
    repeat (16) cycle(1'b1, 1'b0, 0);
    hold_mode = 1'b0;
    drain();

    // Traffic, then a flush while ch1 requests with results in flight
    repeat (20) cycle(1'b1, 1'b0, 50);
    if (!pend[1]) begin pend[1] = 1'b1; samp[1] = 16'h0BEE; end
    cycle(1'b1, 1'b1, 0);
    repeat (8) cycle(1'b1, 1'b0, 0);
    drain();

    // Enable low for 5 cycles mid-stream
    repeat (6) cycle(1'b1, 1'b0, 60);
    repeat (5) cycle(1'b0, 1'b0, 60);
    repeat (6) cycle(1'b1, 1'b0, 60);
    drain();

    // Reset with tags in flight; first grant afterwards goes to ch0
    repeat (4) cycle(1'b1, 1'b0, 100);
    apply_reset(2);
    pend = '1;
    for (int k = 0; k < N; k++) samp[k] = W'($urandom);
    cycle(1'b1, 1'b0, 0);
    drain();

    // Long randomized run with sporadic flushes and enable gaps
    repeat (400) cycle($urandom_range(99) < 85, $urandom_range(99) < 3, 35);
    drain();

`ifdef FILT_FIR_TDM_SCHED_STATS_EN
    apply_reset(2);
    #1 chk("starve_clear", starve, 0);
    pend = '0; pend[3] = 1'b1; samp[3] = 16'h3333;
    repeat (2*N + 4) cycle(1'b0, 1'b0, 0);
    chk("starve_ch3", starve, 4'b1000);
    hold_mode = 1'b1; pend = '1;
    repeat (100) cycle(1'b1, 1'b0, 0);
    hold_mode = 1'b0;
    drain();
    chk("nr_samples", nr_samples, n_res_exp);
`endif

    repeat (4) cycle(1'b0, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filt_fir_tdm_sched.md
Name: filt_fir_tdm_sched

Overview:
- Round-robin scheduler sharing one channel-interleaved filt_fir datapath among gp_nr_ch sample requesters.
- Arbitrates requests and issues one sample per cycle to the filter with a channel tag.
- Tracks filter latency with a tag pipeline and returns each filtered result to its channel.
- Sits between per-channel sample sources (ADC/CIC outputs) and the multi-context FIR.

Parameters:
gp_nr_ch, 4, number of requesting channels (2..16)
gp_inp_width, 16, input sample width
gp_oup_width, 32, filter output width
gp_fir_lat, 3, filter latency in cycles from o_fir_ena to valid i_fir_data (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_ena  in  1  global enable; 0 freezes arbitration and issue, tag pipeline still advances
i_req  in  gp_nr_ch  per-channel request, held until acked
i_data  in  gp_nr_ch*gp_inp_width  flattened channel samples, ch0 in LSBs
i_flush  in  1  single-cycle pulse: drain filter pipeline, block new grants
o_ack  out  gp_nr_ch  one-hot single-cycle acknowledge
o_fir_ena  out  1  sample-valid strobe to filter
o_fir_data  out  gp_inp_width  sample to filter
o_fir_ch  out  clog2(gp_nr_ch)  channel context select to filter
i_fir_data  in  gp_oup_width  filter result
o_valid  out  1  result valid
o_ch  out  clog2(gp_nr_ch)  channel of result
o_data  out  gp_oup_width  registered result
o_busy  out  1  high in FLUSH or while any tag in flight

Behaviour:
- Reset (async, i_rst=1): o_ack=0, o_fir_ena=0, o_fir_data=0, o_fir_ch=0, o_valid=0, o_ch=0, o_data=0, o_busy=0; tag pipeline cleared; rr pointer = gp_nr_ch-1 (ch0 wins first); state IDLE.
- States: IDLE (no pending req), RUN (granting), FLUSH (draining).
- IDLE->RUN when i_ena and |i_req; RUN->IDLE when no req in a cycle; any state->FLUSH on i_flush (flush wins over a simultaneous request, no grant that cycle).
- FLUSH: counter loads gp_fir_lat+1, decrements each cycle; no grants; at 0 -> IDLE. i_flush during FLUSH reloads counter.
- Arbitration (registered): at cycle t, with i_ena=1 and not FLUSH, search from ptr+1 upward modulo gp_nr_ch, first set i_req wins; at t+1: o_ack[winner]=1, o_fir_ena=1, o_fir_data=winner slice, o_fir_ch=winner, ptr=winner.
- Max one grant per cycle; back-to-back grants allowed; ch with held req cannot be granted twice in a row while others request.
- Requester drops i_req the cycle after o_ack, else re-arbitrated as a new sample.
- Tag pipeline: gp_fir_lat stages of {valid, ch} shifted every cycle, entered with o_fir_ena/o_fir_ch.
- Return: when tag exits (cycle t+1+gp_fir_lat) capture i_fir_data; o_valid=1, o_ch, o_data at t+2+gp_fir_lat. Total req-to-result latency gp_fir_lat+2.
- i_ena=0: o_fir_ena=0, no acks, ptr held; in-flight tags still complete.
- o_busy = (state==FLUSH) | any tag valid.
- No width arithmetic; o_data passed unmodified.

Optional Feature:
FILT_FIR_TDM_SCHED_STATS_EN: when defined, adds output o_nr_of_samples (32 bits, wraps) counting o_valid pulses and o_starve (gp_nr_ch bits), sticky per-channel flag set when i_req held >2*gp_nr_ch cycles without ack; both cleared only by i_rst. When undefined, ports and logic are absent.

Test Plan:
- Reset then single req ch2 with data 0x1234, gp_fir_lat=3 -> o_ack=0100 at t+1, o_fir_data=0x1234, o_fir_ch=2; o_valid with o_ch=2 at t+5.
- All 4 req held continuously -> grants cycle 0,1,2,3,0,... one per cycle, no repeats, o_fir_ena high every cycle.
- i_flush while ch1 requesting -> no ack for 4 cycles, o_busy=1, then ch1 acked; in-flight results still returned with correct o_ch.
- i_ena low 5 cycles mid-stream -> no acks/o_fir_ena, ptr held, prior 3 tags emerge in order; resume at next rr channel.
- Assert i_rst with 3 tags in flight -> all outputs 0 immediately, no o_valid afterward, first grant after release goes to ch0.
- STATS_EN: ch3 req with ch0-2 saturating and ch3 masked by bench-forced i_ena pattern >8 cycles -> o_starve[3]=1; 100 results -> o_nr_of_samples=100.
